// File: rtl/ped_signal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ped_signal_ctrl
//  Purpose  : Pedestrian WALK / flashing DON'T WALK controller slaved to the
//             one-hot vehicle traffic-light state.
//  Revision : 1.0  initial release
// ============================================================================
module ped_signal_ctrl #(
  parameter int WALK_CYCLES  = 30,
  parameter int CLEAR_CYCLES = 16,
  parameter int FLASH_HALF   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state_in,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [5:0] countdown,
  output logic       req_pending,
  output logic [1:0] ped_phase
);

  localparam logic [3:0] c_st_off = 4'b0001;
  localparam logic [3:0] c_st_red = 4'b0010;
  localparam logic [3:0] c_st_yel = 4'b0100;
  localparam logic [3:0] c_st_grn = 4'b1000;

  localparam logic [1:0] c_ph_dark      = 2'd0;
  localparam logic [1:0] c_ph_dont_walk = 2'd1;
  localparam logic [1:0] c_ph_walk      = 2'd2;
  localparam logic [1:0] c_ph_clear     = 2'd3;

  localparam logic [5:0] c_walk_load  = 6'(WALK_CYCLES);
  localparam logic [5:0] c_clear_load = 6'(CLEAR_CYCLES);
  localparam logic [3:0] c_flash_load = 4'(FLASH_HALF);

  logic       r_s1, r_s2, r_s2_d;
  logic       r_prev_red;
  logic [1:0] r_phase;
  logic [5:0] r_cnt;
  logic [3:0] r_flash;
  logic       r_walk, r_dont_walk, r_req;
  logic [5:0] r_countdown;

  logic [3:0] w_state;
  logic       w_is_off, w_is_red, w_is_yg;
  logic       w_red_entry, w_btn_edge;
  logic [1:0] w_nph;
  logic [5:0] w_ncnt, w_ncd;
  logic [3:0] w_nflash;
  logic       w_nwalk, w_ndw;

  // Anything other than a clean one-hot code is treated as the lights being off.
  always_comb begin
    w_state = c_st_off;
    case (state_in)
      c_st_off, c_st_red, c_st_yel, c_st_grn: w_state = state_in;
      default:                                w_state = c_st_off;
    endcase
  end

  assign w_is_off    = (w_state == c_st_off);
  assign w_is_red    = (w_state == c_st_red);
  assign w_is_yg     = (w_state == c_st_yel) || (w_state == c_st_grn);
  assign w_red_entry = w_is_red && !r_prev_red;
  assign w_btn_edge  = r_s2 && !r_s2_d;

  always_comb begin
    w_nph    = r_phase;
    w_ncnt   = r_cnt;
    w_nflash = r_flash;
    w_nwalk  = 1'b0;
    w_ndw    = 1'b0;
    w_ncd    = 6'd0;
    if (w_is_off) begin
      w_nph = c_ph_dark;
    end else begin
      case (r_phase)
        c_ph_dark: begin
          w_nph = c_ph_dont_walk;
          w_ndw = 1'b1;
        end
        c_ph_dont_walk: begin
          if (w_red_entry && r_req) begin
            w_nph   = c_ph_walk;
            w_ncnt  = c_walk_load;
            w_nwalk = 1'b1;
          end else begin
            w_ndw = 1'b1;
          end
        end
        c_ph_walk: begin
          if (w_is_yg) begin
            w_nph = c_ph_dont_walk;
            w_ndw = 1'b1;
          end else if (r_cnt <= 6'd1) begin
            w_nph    = c_ph_clear;
            w_ncnt   = c_clear_load;
            w_ncd    = c_clear_load;
            w_nflash = c_flash_load;
            w_ndw    = 1'b1;
          end else begin
            w_ncnt  = r_cnt - 6'd1;
            w_nwalk = 1'b1;
          end
        end
        default: begin
          if (w_is_yg || r_cnt <= 6'd1) begin
            w_nph = c_ph_dont_walk;
            w_ndw = 1'b1;
          end else begin
            w_ncnt = r_cnt - 6'd1;
            w_ncd  = r_cnt - 6'd1;
            // dont_walk itself holds the flash level; toggle at each half-period end
            if (r_flash <= 4'd1) begin
              w_ndw    = !r_dont_walk;
              w_nflash = c_flash_load;
            end else begin
              w_ndw    = r_dont_walk;
              w_nflash = r_flash - 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s2_d      <= 1'b0;
      r_prev_red  <= 1'b0;
      r_phase     <= c_ph_dark;
      r_cnt       <= 6'd0;
      r_flash     <= 4'd0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b0;
      r_countdown <= 6'd0;
      r_req       <= 1'b0;
    end else begin
      r_s1        <= ped_btn;
      r_s2        <= r_s1;
      r_s2_d      <= r_s2;
      r_prev_red  <= w_is_red;
      r_phase     <= w_nph;
      r_cnt       <= w_ncnt;
      r_flash     <= w_nflash;
      r_walk      <= w_nwalk;
      r_dont_walk <= w_ndw;
      r_countdown <= w_ncd;
      // A press landing on the WALK-entry cycle survives for the next RED.
      if (r_phase == c_ph_dark || w_nph == c_ph_dark)
        r_req <= 1'b0;
      else if (w_btn_edge)
        r_req <= 1'b1;
      else if (r_phase == c_ph_dont_walk && w_nph == c_ph_walk)
        r_req <= 1'b0;
    end
  end

  assign walk        = r_walk;
  assign dont_walk   = r_dont_walk;
  assign countdown   = r_countdown;
  assign req_pending = r_req;
  assign ped_phase   = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_ped_signal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ped_signal_ctrl
//  Purpose  : Directed scoreboard bench for ped_signal_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ped_signal_ctrl;

  localparam logic [3:0] OFF = 4'b0001;
  localparam logic [3:0] RED = 4'b0010;
  localparam logic [3:0] YEL = 4'b0100;
  localparam logic [3:0] GRN = 4'b1000;

  typedef struct packed {
    logic       walk;
    logic       dw;
    logic [5:0] cd;
    logic       req;
    logic [1:0] ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_in;
  logic       ped_btn;
  logic       walk, dont_walk, req_pending;
  logic [5:0] countdown;
  logic [1:0] ped_phase;

  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;
  exp_t exp_q[$];
  logic [15:0] pat = 16'b1111000011110000;

  ped_signal_ctrl #(.WALK_CYCLES(30), .CLEAR_CYCLES(16), .FLASH_HALF(4)) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .countdown(countdown),
    .req_pending(req_pending), .ped_phase(ped_phase)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic w, logic d, logic [5:0] c, logic r, logic [1:0] p);
    exp_t e;
    e.walk = w; e.dw = d; e.cd = c; e.req = r; e.ph = p;
    return e;
  endfunction

  function automatic exp_t DK();
    return mk(1'b0, 1'b0, 6'd0, 1'b0, 2'd0);
  endfunction
  function automatic exp_t DW(logic r);
    return mk(1'b0, 1'b1, 6'd0, r, 2'd1);
  endfunction
  function automatic exp_t WK(logic r);
    return mk(1'b1, 1'b0, 6'd0, r, 2'd2);
  endfunction
  function automatic exp_t CL(int i);
    return mk(1'b0, pat[15-i], 6'(16 - i), 1'b0, 2'd3);
  endfunction

  task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, n_cyc, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic cyc(logic [3:0] st, logic btn, exp_t e);
    exp_t g;
    state_in = st;
    ped_btn  = btn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
    g = exp_q.pop_front();
    chk("walk",        {5'd0, walk},        {5'd0, g.walk});
    chk("dont_walk",   {5'd0, dont_walk},   {5'd0, g.dw});
    chk("countdown",   countdown,           g.cd);
    chk("req_pending", {5'd0, req_pending}, {5'd0, g.req});
    chk("ped_phase",   {4'd0, ped_phase},   {4'd0, g.ph});
  endtask

  initial begin
    reset = 1'b1; state_in = OFF; ped_btn = 1'b0;
    #1;
    // reset with lights off
    cyc(OFF, 0, DK());
    cyc(OFF, 0, DK());
    reset = 1'b0;
    cyc(GRN, 0, DW(0));

    // press in GREEN, full WALK + CLEAR at RED entry
    cyc(GRN, 1, DW(0));
    cyc(GRN, 0, DW(0));
    cyc(GRN, 0, DW(1));
    cyc(GRN, 0, DW(1));
    cyc(YEL, 0, DW(1));
    for (int i = 0; i < 30; i++) cyc(RED, 0, WK(0));
    for (int i = 0; i < 16; i++) cyc(RED, 0, CL(i));
    cyc(RED, 0, DW(0));
    cyc(RED, 0, DW(0));

    // no request at RED entry; press during RED waits for next RED
    cyc(YEL, 0, DW(0));
    cyc(GRN, 0, DW(0));
    cyc(RED, 0, DW(0));
    for (int i = 0; i < 4; i++) cyc(RED, 0, DW(0));
    cyc(RED, 1, DW(0));
    cyc(RED, 0, DW(0));
    cyc(RED, 0, DW(1));
    for (int i = 0; i < 3; i++) cyc(RED, 0, DW(1));
    cyc(YEL, 0, DW(1));
    cyc(GRN, 0, DW(1));
    cyc(RED, 0, WK(0));

    // abort WALK on YELLOW
    for (int i = 0; i < 4; i++) cyc(RED, 0, WK(0));
    cyc(YEL, 0, DW(0));

    // OFF during CLEAR
    cyc(GRN, 1, DW(0));
    cyc(GRN, 0, DW(0));
    cyc(GRN, 0, DW(1));
    cyc(YEL, 0, DW(1));
    for (int i = 0; i < 30; i++) cyc(RED, 0, WK(0));
    for (int i = 0; i < 5; i++) cyc(RED, 0, CL(i));
    cyc(OFF, 0, DK());

    // button held for 100 cycles yields a single request
    for (int i = 0; i < 100; i++) begin
      logic [3:0] st;
      exp_t e;
      st = (i < 10) ? GRN : (i < 12) ? YEL : RED;
      if (i < 2)       e = DW(0);
      else if (i < 12) e = DW(1);
      else if (i < 42) e = WK(0);
      else if (i < 58) e = CL(i - 42);
      else             e = DW(0);
      cyc(st, 1, e);
    end
    for (int i = 0; i < 3; i++) cyc(RED, 0, DW(0));

    // press edge lands on the WALK-entry cycle
    cyc(YEL, 1, DW(0));
    cyc(YEL, 0, DW(0));
    cyc(YEL, 0, DW(1));
    cyc(YEL, 1, DW(1));
    cyc(YEL, 0, DW(1));
    cyc(RED, 0, WK(1));
    cyc(RED, 0, WK(1));
    cyc(YEL, 0, DW(1));
    cyc(GRN, 0, DW(1));
    cyc(RED, 0, WK(0));
    cyc(RED, 0, WK(0));

    // illegal state codes behave as OFF
    cyc(4'b0011, 0, DK());
    cyc(GRN, 0, DW(0));
    cyc(4'b0011, 0, DK());

    // reset mid-WALK
    cyc(GRN, 1, DW(0));
    cyc(GRN, 0, DW(0));
    cyc(GRN, 0, DW(1));
    cyc(YEL, 0, DW(1));
    cyc(RED, 0, WK(0));
    cyc(RED, 0, WK(0));
    reset = 1'b1;
    cyc(RED, 0, DK());
    reset = 1'b0;
    cyc(RED, 0, DW(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
